// File: rtl/ir_remote_rx_if.sv
// ir_remote_rx_if: connection bundle between the IR receiver and its consumer.
//   irda    - IR demodulator output, idle high, burst low (driven by the board pin side)
//   rdy     - one-cycle pulse when a frame (or repeat) has been decoded
//   addr    - address byte of the last valid frame
//   code    - command byte of the last valid frame
//   buttons - one-hot matched button, valid only while rdy is high
//   color   - index of the last matched button, held
//   hit     - last valid frame matched a key, held
//   rpt     - qualifies rdy as a repeat frame
// Modports: master = receiver side, slave = pin/consumer side.
interface ir_remote_rx_if #(
   parameter int unsigned NBTN = 5
);
   localparam int unsigned COLOR_W = (NBTN > 1) ? $clog2(NBTN) : 1;

   logic               irda;
   logic               rdy;
   logic [7:0]         addr;
   logic [7:0]         code;
   logic [NBTN-1:0]    buttons;
   logic [COLOR_W-1:0] color;
   logic               hit;
   logic               rpt;

   modport master (
      input  irda,
      output rdy, addr, code, buttons, color, hit, rpt
   );

   modport slave (
      output irda,
      input  rdy, addr, code, buttons, color, hit, rpt
   );
endinterface

// File: rtl/ir_remote_rx.sv
// ir_remote_rx: NEC-style pulse-distance IR frame decoder with button mapping.
// Decodes leader + 32 data bits (LSB first) + stop burst from the active-low
// demodulator output, validates the complement bytes and maps the command byte
// onto NBTN buttons through KEY_MAP (byte i = button i, lowest index wins).
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - ir_remote_rx_if.master: irda in; rdy/addr/code/buttons/color/hit/rpt out
// Optional feature: define IR_REMOTE_RX_REPEAT_EN to decode NEC repeat frames
// (16 units low, 4 units high, 1 unit low). Without it rpt is tied to 0.
module ir_remote_rx #(
   parameter int unsigned        UNIT_TICKS = 6,
   parameter int unsigned        TOL_TICKS  = 2,
   parameter int unsigned        NBTN       = 5,
   parameter logic [NBTN*8-1:0]  KEY_MAP    = {8'h04, 8'h03, 8'h02, 8'h01, 8'h12},
   parameter bit                 CHECK_INV  = 1'b1
) (
   input logic            clk,
   input logic            rst,
   ir_remote_rx_if.master bus
);

   localparam int unsigned COLOR_W = (NBTN > 1) ? $clog2(NBTN) : 1;
   localparam int unsigned CNT_MAX = 20 * UNIT_TICKS + 1;
   localparam int unsigned CNT_W   = $clog2(20 * UNIT_TICKS + 2);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_LEAD_LO  = 4'd1;
   localparam logic [3:0] S_LEAD_HI  = 4'd2;
   localparam logic [3:0] S_BIT_LO   = 4'd3;
   localparam logic [3:0] S_BIT_HI   = 4'd4;
   localparam logic [3:0] S_STOP     = 4'd5;
   localparam logic [3:0] S_CHECK    = 4'd7;
   localparam logic [3:0] S_EMIT     = 4'd8;
`ifdef IR_REMOTE_RX_REPEAT_EN
   localparam logic [3:0] S_REP_STOP = 4'd6;
`endif

   // Level of L ticks counts as k units when it is within TOL_TICKS of k*UNIT_TICKS.
   function automatic logic is_units(input logic [CNT_W-1:0] len, input int unsigned k);
      int l;
      int c;
      l = int'(len);
      c = int'(k * UNIT_TICKS);
      return (l >= c - int'(TOL_TICKS)) && (l <= c + int'(TOL_TICKS));
   endfunction

   function automatic logic [NBTN-1:0] onehot(input logic [COLOR_W-1:0] idx);
      return NBTN'(1) << idx;
   endfunction

   // ------------------------------------------------------------------
   // Synchroniser and edge detection
   // ------------------------------------------------------------------
   logic irda_s1, irda_s2, irda_s3;
   logic fall, rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         irda_s1 <= 1'b1;
         irda_s2 <= 1'b1;
         irda_s3 <= 1'b1;
      end else begin
         irda_s1 <= bus.irda;
         irda_s2 <= irda_s1;
         irda_s3 <= irda_s2;
      end
   end

   assign fall = irda_s3 & ~irda_s2;
   assign rise = ~irda_s3 & irda_s2;

   // ------------------------------------------------------------------
   // Level-duration counter: on an edge cycle cnt_q holds the length of the
   // level that just ended; restarting at 1 keeps that true for the next one.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic             sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (fall || rise) begin
         cnt_q <= CNT_W'(1);
      end else if (cnt_q != CNT_SAT) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign sat = (cnt_q == CNT_SAT);

   logic u1, u3, u4, u8, u16;
   assign u1  = is_units(cnt_q, 1);
   assign u3  = is_units(cnt_q, 3);
   assign u4  = is_units(cnt_q, 4);
   assign u8  = is_units(cnt_q, 8);
   assign u16 = is_units(cnt_q, 16);

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   logic [3:0]  state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] sr_q, sr_d;
   logic        rep_q, rep_d;
   logic        waiting;

   // States that wait on an irda edge and are therefore subject to timeout.
   assign waiting = (state_q != S_IDLE) && (state_q != S_CHECK) && (state_q != S_EMIT);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      rep_d     = rep_q;
      case (state_q)
         S_IDLE: begin
            if (fall) state_d = S_LEAD_LO;
         end
         S_LEAD_LO: begin
            if (rise) state_d = u16 ? S_LEAD_HI : S_IDLE;
         end
         S_LEAD_HI: begin
            if (fall) begin
               if (u8) begin
                  state_d   = S_BIT_LO;
                  bit_cnt_d = 5'd0;
               end
`ifdef IR_REMOTE_RX_REPEAT_EN
               else if (u4) begin
                  state_d = S_REP_STOP;
               end
`endif
               else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_BIT_LO: begin
            if (rise) state_d = u1 ? S_BIT_HI : S_IDLE;
         end
         S_BIT_HI: begin
            if (fall) begin
               if (u1 || u3) begin
                  sr_d = {u3, sr_q[31:1]};
                  if (bit_cnt_q == 5'd31) begin
                     state_d = S_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                     state_d   = S_BIT_LO;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_STOP: begin
            if (rise) begin
               state_d = u1 ? S_CHECK : S_IDLE;
               rep_d   = 1'b0;
            end
         end
`ifdef IR_REMOTE_RX_REPEAT_EN
         S_REP_STOP: begin
            if (rise) begin
               state_d = u1 ? S_CHECK : S_IDLE;
               rep_d   = 1'b1;
            end
         end
`endif
         S_CHECK: state_d = S_EMIT;
         S_EMIT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (waiting && sat) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         rep_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         rep_q     <= rep_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame check and key match, registered in S_CHECK and consumed in S_EMIT
   // so the priority matcher is not in series with the output registers.
   // ------------------------------------------------------------------
   logic               frame_ok;
   logic               m_hit;
   logic [COLOR_W-1:0] m_idx;

   assign frame_ok = (CHECK_INV == 1'b0) ||
                     ((sr_q[15:8] == ~sr_q[7:0]) && (sr_q[31:24] == ~sr_q[23:16]));

   always_comb begin
      m_hit = 1'b0;
      m_idx = '0;
      // Descending scan so the lowest matching index is the one left standing.
      for (int i = int'(NBTN) - 1; i >= 0; i--) begin
         if (KEY_MAP[i*8 +: 8] == sr_q[23:16]) begin
            m_hit = 1'b1;
            m_idx = COLOR_W'(i);
         end
      end
   end

   logic               chk_ok_q;
   logic               chk_hit_q;
   logic [COLOR_W-1:0] chk_idx_q;
   logic               have_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         chk_ok_q  <= 1'b0;
         chk_hit_q <= 1'b0;
         chk_idx_q <= '0;
      end else if (state_q == S_CHECK) begin
         // A repeat is only honoured once a real frame has been seen.
         chk_ok_q  <= rep_q ? have_valid_q : frame_ok;
         chk_hit_q <= m_hit;
         chk_idx_q <= m_idx;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   logic               rdy_q;
   logic [7:0]         addr_q;
   logic [7:0]         code_q;
   logic [NBTN-1:0]    buttons_q;
   logic [COLOR_W-1:0] color_q;
   logic               hit_q;
   logic               emit;
`ifdef IR_REMOTE_RX_REPEAT_EN
   logic               rpt_q;
`endif

   assign emit = (state_q == S_EMIT) && chk_ok_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q        <= 1'b0;
         addr_q       <= '0;
         code_q       <= '0;
         buttons_q    <= '0;
         color_q      <= '0;
         hit_q        <= 1'b0;
         have_valid_q <= 1'b0;
`ifdef IR_REMOTE_RX_REPEAT_EN
         rpt_q        <= 1'b0;
`endif
      end else begin
         rdy_q     <= emit;
         buttons_q <= '0;
`ifdef IR_REMOTE_RX_REPEAT_EN
         rpt_q     <= emit && rep_q;
`endif
         if (emit) begin
            if (rep_q) begin
               // Repeat re-presents the previous match; held outputs stay put.
               buttons_q <= hit_q ? onehot(color_q) : '0;
            end else begin
               addr_q       <= sr_q[7:0];
               code_q       <= sr_q[23:16];
               hit_q        <= chk_hit_q;
               have_valid_q <= 1'b1;
               if (chk_hit_q) begin
                  color_q   <= chk_idx_q;
                  buttons_q <= onehot(chk_idx_q);
               end
            end
         end
      end
   end

   assign bus.rdy     = rdy_q;
   assign bus.addr    = addr_q;
   assign bus.code    = code_q;
   assign bus.buttons = buttons_q;
   assign bus.color   = color_q;
   assign bus.hit     = hit_q;
`ifdef IR_REMOTE_RX_REPEAT_EN
   assign bus.rpt     = rpt_q;
`else
   assign bus.rpt     = 1'b0;
`endif

endmodule

// File: tb/tb_ir_remote_rx.sv
// tb_ir_remote_rx: scoreboard bench for ir_remote_rx.
// Two receivers share one irda line: u_dut0 checks complements, u_dut1 does not.
// Stimulus pushes expected responses from a frame-level model; a negedge
// monitor pops and compares whenever a receiver raises rdy.
module tb_ir_remote_rx;

   localparam int U = 6;

   logic clk = 1'b0;
   logic rst;
   logic irda;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ir_remote_rx_if #(.NBTN(5)) bus0 ();
   ir_remote_rx_if #(.NBTN(5)) bus1 ();
   assign bus0.irda = irda;
   assign bus1.irda = irda;

   ir_remote_rx #(.UNIT_TICKS(6), .TOL_TICKS(2), .NBTN(5), .CHECK_INV(1'b1)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   ir_remote_rx #(.UNIT_TICKS(6), .TOL_TICKS(2), .NBTN(5), .CHECK_INV(1'b0)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct {
      logic       rpt;
      logic [7:0] addr;
      logic [7:0] code;
      logic [4:0] btn;
      logic [2:0] color;
      logic       hit;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Frame-level model state per receiver.
   logic [7:0] keys [5] = '{8'h12, 8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] m_addr  [2];
   logic [7:0] m_code  [2];
   logic [2:0] m_color [2];
   logic       m_hit   [2];
   logic       m_valid [2];
   logic [4:0] m_btn   [2];

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d: got %h, want %h (cycle %0d)", name, k, act, exp, cyc);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_addr[k]  = '0;
         m_code[k]  = '0;
         m_color[k] = '0;
         m_hit[k]   = 1'b0;
         m_valid[k] = 1'b0;
         m_btn[k]   = '0;
      end
   endtask

   task automatic push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int exp_cyc);
      int   idx;
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (k == 1 || (b1 == ~b0 && b3 == ~b2)) begin
            idx = -1;
            for (int i = 0; i < 5; i++) if (idx < 0 && keys[i] == b2) idx = i;
            m_addr[k]  = b0;
            m_code[k]  = b2;
            m_hit[k]   = (idx >= 0);
            if (idx >= 0) m_color[k] = 3'(idx);
            m_btn[k]   = (idx >= 0) ? 5'(1 << idx) : 5'd0;
            m_valid[k] = 1'b1;
            e = '{1'b0, m_addr[k], m_code[k], m_btn[k], m_color[k], m_hit[k], exp_cyc};
            push(k, e);
         end
      end
   endtask

   task automatic model_repeat();
`ifdef IR_REMOTE_RX_REPEAT_EN
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (m_valid[k]) begin
            e = '{1'b1, m_addr[k], m_code[k], m_btn[k], m_color[k], m_hit[k], -1};
            push(k, e);
         end
      end
`endif
   endtask

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   task automatic mon_one(input int k, input logic rdy, input logic rpt, input logic [7:0] a,
                          input logic [7:0] c, input logic [4:0] b, input logic [2:0] col,
                          input logic h);
      exp_t e;
      int   qs;
      qs = (k == 0) ? q0.size() : q1.size();
      if (rdy) begin
         if (qs == 0) begin
            check("unexpected_rdy", k, 32'(rdy), 32'd0);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check("rpt", k, 32'(rpt), 32'(e.rpt));
            check("addr", k, 32'(a), 32'(e.addr));
            check("code", k, 32'(c), 32'(e.code));
            check("buttons", k, 32'(b), 32'(e.btn));
            check("color", k, 32'(col), 32'(e.color));
            check("hit", k, 32'(h), 32'(e.hit));
            if (e.cyc >= 0) check("latency", k, 32'(cyc), 32'(e.cyc));
         end
      end else begin
         check("idle_buttons_rpt", k, 32'({b, rpt}), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon_one(0, bus0.rdy, bus0.rpt, bus0.addr, bus0.code, bus0.buttons, bus0.color, bus0.hit);
         mon_one(1, bus1.rdy, bus1.rpt, bus1.addr, bus1.code, bus1.buttons, bus1.color, bus1.hit);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic send_level(input logic v, input int ticks);
      irda = v;
      repeat (ticks) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic irda_low);
      rst  = 1'b1;
      irda = irda_low ? 1'b0 : 1'b1;
      repeat (3) @(posedge clk);
      #1;
      irda = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // fault: 0 clean, 1 short leader, 2 bit high stretched at bit farg, 3 reset at bit farg
   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int fault, input int farg,
                             input int gap);
      logic [31:0] w;
      int          sc;
      w = {b3, b2, b1, b0};
      send_level(1'b0, (fault == 1 ? 11 : 16) * U);
      send_level(1'b1, 8 * U);
      for (int i = 0; i < 32; i++) begin
         if (fault == 3 && i == farg) begin
            do_reset(1'b0);
            return;
         end
         send_level(1'b0, U);
         if (fault == 2 && i == farg) begin
            send_level(1'b1, 25 * U);
            return;
         end
         send_level(1'b1, w[i] ? 3 * U : U);
      end
      send_level(1'b0, U);
      irda = 1'b1;
      sc   = cyc;
      if (fault == 0) model_frame(b0, b1, b2, b3, sc + 5);
      repeat (gap * U) @(posedge clk);
      #1;
   endtask

   task automatic send_repeat(input int gap);
      send_level(1'b0, 16 * U);
      send_level(1'b1, 4 * U);
      send_level(1'b0, U);
      irda = 1'b1;
      model_repeat();
      repeat (gap * U) @(posedge clk);
      #1;
   endtask

   // Held outputs against the model, and nothing still owed by either receiver.
   task automatic check_held();
      @(negedge clk);
      check("held_addr", 0, 32'(bus0.addr), 32'(m_addr[0]));
      check("held_code", 0, 32'(bus0.code), 32'(m_code[0]));
      check("held_color", 0, 32'(bus0.color), 32'(m_color[0]));
      check("held_hit", 0, 32'(bus0.hit), 32'(m_hit[0]));
      check("held_addr", 1, 32'(bus1.addr), 32'(m_addr[1]));
      check("held_code", 1, 32'(bus1.code), 32'(m_code[1]));
      check("held_color", 1, 32'(bus1.color), 32'(m_color[1]));
      check("held_hit", 1, 32'(bus1.hit), 32'(m_hit[1]));
      check("missing_rdy", 0, 32'(q0.size()), 32'd0);
      check("missing_rdy", 1, 32'(q1.size()), 32'd0);
      q0.delete();
      q1.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a, c, b1, b3;
      int         r;

      model_reset();
      do_reset(1'b1);
      @(negedge clk);
      check("reset_rdy", 0, 32'(bus0.rdy), 32'd0);
      check("reset_rdy", 1, 32'(bus1.rdy), 32'd0);
      check("reset_buttons", 0, 32'(bus0.buttons), 32'd0);
      check("reset_rpt", 0, 32'(bus0.rpt), 32'd0);
      check_held();

      // Repeat with no prior valid frame is ignored.
      send_repeat(2);
      check_held();

      send_frame(8'h00, 8'hFF, 8'h03, 8'hFC, 0, 0, 2);
      check_held();
      send_frame(8'h5A, 8'hA5, 8'h55, 8'hAA, 0, 0, 1);
      check_held();
      // Corrupted ~cmd: dropped by the checking receiver only.
      send_frame(8'h10, 8'hEF, 8'h02, 8'hFC, 0, 0, 2);
      check_held();

      send_frame(8'h00, 8'hFF, 8'h12, 8'hED, 1, 0, 2);
      check_held();
      send_frame(8'h00, 8'hFF, 8'h12, 8'hED, 2, 9, 2);
      check_held();
      send_frame(8'h00, 8'hFF, 8'h12, 8'hED, 3, 12, 2);
      check_held();
      send_frame(8'h00, 8'hFF, 8'h12, 8'hED, 0, 0, 2);
      check_held();

      send_frame(8'h33, 8'hCC, 8'h01, 8'hFE, 0, 0, 1);
      send_repeat(2);
      check_held();

      for (int n = 0; n < 16; n++) begin
         a  = 8'($urandom);
         c  = ($urandom_range(0, 1) == 1) ? keys[$urandom_range(0, 4)] : 8'($urandom);
         b1 = ~a;
         b3 = ~c;
         r  = int'($urandom_range(0, 3));
         if (r == 0) b3 = b3 ^ 8'(1 << $urandom_range(0, 7));
         else if (r == 1) b1 = b1 ^ 8'h10;
         send_frame(a, b1, c, b3, 0, 0, int'($urandom_range(1, 3)));
         if ($urandom_range(0, 2) == 0) send_repeat(int'($urandom_range(1, 3)));
         check_held();
      end

      repeat (20) @(posedge clk);
      check_held();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ir_remote_rx.md
Name: ir_remote_rx

Overview:
- Parametrised successor to the game's IR remote-control receiver.
- Decodes NEC-style pulse-distance frames from the active-low IR demodulator output `irda`.
- Frame content: leader, 32 data bits, stop burst.
- Validates each frame and maps the command byte onto a configurable set of game buttons (power, blue, yellow, green, red by default).
- Sits between the board IR pin and the game-control FSM, which consumes `rdy` and the button outputs.

Parameters:
- UNIT_TICKS, 6, clock ticks per timing unit (one NEC 562.5 us unit; 6 = simulation scale).
- TOL_TICKS, 2, allowed ± deviation in ticks when classifying a pulse as k units.
- NBTN, 5, number of mapped buttons.
- KEY_MAP, {8'h04,8'h03,8'h02,8'h01,8'h12}, NBTN×8 packed command codes; byte i is button i.
- CHECK_INV, 1, when 1 the complement bytes must match or the frame is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- irda  in  1  IR demodulator output; idle high, burst = low; asynchronous
- rdy  out  1  one-cycle pulse: valid frame (or repeat) decoded
- addr  out  8  address byte of last valid frame
- code  out  8  command byte of last valid frame
- buttons  out  NBTN  one-hot matched button, valid while rdy=1; otherwise 0
- color  out  max(1,$clog2(NBTN))  index of matched button, held until next valid frame
- hit  out  1  last valid frame matched a KEY_MAP entry, held
- rpt  out  1  qualifies rdy as a repeat frame; 0 when REPEAT_EN is undefined

Behaviour:
- Clock, reset, synchronisation:
  - One clock domain. Reset is synchronous and active-high.
  - `irda` passes through a 2-FF synchroniser plus one edge-detect register.
  - Both synchroniser FFs reset to 1.
- Reset values: rdy=0, addr=0, code=0, buttons=0, color=0, hit=0, rpt=0, FSM=IDLE, counters=0, shift register=0.
- Level-duration counter:
  - Counts ticks since the last synced edge and saturates at 20×UNIT_TICKS+1.
  - Width is $clog2(20×UNIT_TICKS+2).
- Pulse classification: a level of L ticks equals k units iff |L − k×UNIT_TICKS| ≤ TOL_TICKS.
- FSM transitions:
  - IDLE → LEAD_LO on a synced falling edge.
  - LEAD_LO: on the rising edge, 16 units → LEAD_HI; otherwise → IDLE.
  - LEAD_HI: on the falling edge, 8 units → BIT_LO with bit count 0; 4 units → REP_STOP (REPEAT_EN only); otherwise → IDLE.
  - BIT_LO: on the rising edge, 1 unit → BIT_HI; otherwise → IDLE.
  - BIT_HI: on the falling edge, 1 unit shifts in 0 and 3 units shifts in 1; otherwise → IDLE.
    - Data is shifted LSB-first into a 32-bit register.
    - After bit 31 → STOP; otherwise → BIT_LO.
  - STOP: on the rising edge, 1 unit → frame check; otherwise → IDLE.
  - REP_STOP: on the rising edge, 1 unit → repeat check; otherwise → IDLE.
- Timeout: in any non-IDLE state, the counter saturating (no edge for >20 units) forces IDLE with no output change.
- Frame check:
  - Bytes are b0=addr, b1=~addr, b2=cmd, b3=~cmd.
  - With CHECK_INV=1, b1≠~b0 or b3≠~b2 drops the frame silently.
  - On a valid frame, addr/code/hit/color update and rdy/buttons pulse for exactly one cycle.
  - Latency: rdy is high in the 4th clk cycle after the cycle in which raw `irda` is first sampled high at the end of the stop burst.
- Key match:
  - Lowest index i with KEY_MAP[i] = cmd wins.
  - No match: hit=0, buttons=0 during the pulse, color unchanged; rdy still pulses.
- Mid-operation and simultaneous events:
  - A falling edge arriving while IDLE is processed immediately.
  - Frames back-to-back with a ≥1 unit gap are all decoded.
  - Reset mid-frame discards the partial frame; the next frame must start with a full leader.

Optional Feature:
- Macro: IR_REMOTE_RX_REPEAT_EN
- Defined:
  - The REP_STOP path exists.
  - A repeat frame (16 low, 4 high, 1 low, then rising edge) pulses rdy=1 and rpt=1 for one cycle.
  - buttons repeat the last valid match (0 if hit=0); addr/code/color are unchanged.
  - A repeat arriving before any valid frame since reset is ignored.
- Undefined:
  - LEAD_HI of 4 units → IDLE.
  - rpt is constant 0.

Test Plan (clk period 10 ns, UNIT_TICKS=6, so 1 unit = 60 ns):
- Reset held 5 cycles with irda=1 → all outputs 0; irda low during reset produces no state change.
- Full frame addr=0x00, cmd=0x03 → one rdy pulse; buttons=5'b01000, color=3, code=8'h03, addr=8'h00, hit=1; rdy at the required 4-cycle latency.
- Frame cmd=0x55, valid complements → rdy pulse, hit=0, buttons=0, color retains 3.
- Frame with cmd=0x02, ~cmd byte corrupted to 0xFC, CHECK_INV=1 → no rdy, outputs unchanged. Same frame with CHECK_INV=0 → rdy, buttons=5'b00100.
- Leader low of 11 units, separately bit high held 25 units, separately rst pulsed at bit 12 → no rdy in each case. A following clean cmd=0x12 frame → buttons=5'b00001, color=0.
- REPEAT_EN defined: after cmd=0x01, send a repeat frame → rdy=1, rpt=1, buttons=5'b00010. Repeat sent straight after reset → no rdy. REPEAT_EN undefined: same repeat → no rdy, rpt=0 throughout.
